// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues reads to imemory and buffers
// returned words in an in-order queue presented to decode over valid/ready.
module fetch_unit #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int unsigned MEM_DEPTH   = 1024,
   parameter int unsigned QUEUE_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   output logic        imem_read_en,
   input  logic [31:0] imem_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_insn,
   output logic        out_fault
);

   localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
   localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
   localparam logic [31:0] PC_LIMIT = 32'(MEM_DEPTH - 3);
   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_HALT = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [31:0] q_pc_q    [QUEUE_DEPTH];
   logic [31:0] q_insn_q  [QUEUE_DEPTH];
   logic        q_fault_q [QUEUE_DEPTH];

   logic        pop;
   logic        space;
   logic        fault;
   logic        push;
   logic [31:0] push_insn;
   logic        push_fault;

   assign pop   = (count_q != '0) && out_ready;
   assign space = (count_q < CNT_W'(QUEUE_DEPTH)) || pop;
   assign fault = (pc_q[1:0] != 2'b00) || pc_q[31] || (pc_q >= PC_LIMIT);

   // Redirect outranks fetch; reset only needs to mask the read strobe here.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      count_d      = count_q;
      push         = 1'b0;
      push_insn    = imem_data;
      push_fault   = 1'b0;
      imem_read_en = 1'b0;

      if (redirect_valid) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
         pc_d     = redirect_pc;
         state_d  = ST_RUN;
      end else begin
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         if ((state_q == ST_RUN) && space) begin
            push = 1'b1;
            if (!fault) begin
               imem_read_en = 1'b1;
               pc_d         = pc_q + 32'd4;
            end else begin
               push_insn  = NOP_INSN;
               push_fault = 1'b1;
               state_d    = ST_HALT;
            end
         end
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end

      if (rst) begin
         imem_read_en = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_RUN;
         pc_q     <= RESET_PC;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Queue storage needs no reset: entries are only visible while counted.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         q_pc_q[wr_ptr_q]    <= pc_q;
         q_insn_q[wr_ptr_q]  <= push_insn;
         q_fault_q[wr_ptr_q] <= push_fault;
      end
   end

   assign imem_addr = pc_q;
   assign out_valid = (count_q != '0);
   assign out_pc    = out_valid ? q_pc_q[rd_ptr_q]   : 32'h0;
   assign out_insn  = out_valid ? q_insn_q[rd_ptr_q] : 32'h0;
   assign out_fault = out_valid ? q_fault_q[rd_ptr_q] : 1'b0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus a throughput
// run and a bounded wait for a bounds fault.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] imem_addr;
   logic        imem_read_en;
   logic [31:0] imem_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_insn;
   logic        out_fault;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(32'h0), .MEM_DEPTH(1024), .QUEUE_DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .imem_addr(imem_addr), .imem_read_en(imem_read_en), .imem_data(imem_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_insn(out_insn), .out_fault(out_fault)
   );

   // Memory model: two real instructions, then an address-tagged pattern.
   function automatic logic [31:0] memval(input logic [31:0] a);
      if (a == 32'h0) return 32'h0050_0093;
      if (a == 32'h4) return 32'h00a0_0113;
      return 32'hC000_0000 | a;
   endfunction

   assign imem_data = memval(imem_addr);

   typedef struct packed {
      logic [31:0] addr;
      logic        ren;
      logic        ov;
      logic [31:0] opc;
      logic [31:0] insn;
      logic        flt;
   } outs_t;

   typedef struct {
      logic        rst;
      logic        rv;
      logic [31:0] rpc;
      logic        rdy;
      outs_t       exp;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy,
                      input logic [31:0] addr, input logic ren, input logic ov,
                      input logic [31:0] opc, input logic [31:0] insn, input logic flt);
      vec_t v;
      v.rst = r; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
      v.exp = '{addr: addr, ren: ren, ov: ov, opc: opc, insn: insn, flt: flt};
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input outs_t exp);
      outs_t act;
      act = '{addr: imem_addr, ren: imem_read_en, ov: out_valid,
              opc: out_pc, insn: out_insn, flt: out_fault};
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got addr=%h ren=%b ov=%b pc=%h insn=%h flt=%b, want addr=%h ren=%b ov=%b pc=%h insn=%h flt=%b",
                  name, act.addr, act.ren, act.ov, act.opc, act.insn, act.flt,
                  exp.addr, exp.ren, exp.ov, exp.opc, exp.insn, exp.flt);
      end
   endtask

   task automatic check_bit(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   initial begin
      rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
      @(posedge clk); #1;

      //   rst rv rpc          rdy  addr         ren ov pc           insn          flt
      // reset state, then basic stream
      add(1, 0, 32'h0,        1,   32'h0,       0,  0, 32'h0,       32'h0,        0);
      add(0, 0, 32'h0,        1,   32'h0,       1,  0, 32'h0,       32'h0,        0);
      add(0, 0, 32'h0,        1,   32'h4,       1,  1, 32'h0,       32'h0050_0093, 0);
      add(0, 0, 32'h0,        1,   32'h8,       1,  1, 32'h4,       32'h00a0_0113, 0);
      // reset, then backpressure for 10 cycles
      add(1, 0, 32'h0,        0,   32'hC,       0,  1, 32'h8,       32'hC000_0008, 0);
      add(0, 0, 32'h0,        0,   32'h0,       1,  0, 32'h0,       32'h0,        0);
      add(0, 0, 32'h0,        0,   32'h4,       1,  1, 32'h0,       32'h0050_0093, 0);
      add(0, 0, 32'h0,        0,   32'h8,       1,  1, 32'h0,       32'h0050_0093, 0);
      add(0, 0, 32'h0,        0,   32'hC,       1,  1, 32'h0,       32'h0050_0093, 0);
      for (int i = 0; i < 6; i++)
         add(0, 0, 32'h0,     0,   32'h10,      0,  1, 32'h0,       32'h0050_0093, 0);
      // release: in-order drain, fetch of 0x10 in first pop cycle
      add(0, 0, 32'h0,        1,   32'h10,      1,  1, 32'h0,       32'h0050_0093, 0);
      add(0, 0, 32'h0,        1,   32'h14,      1,  1, 32'h4,       32'h00a0_0113, 0);
      add(0, 0, 32'h0,        1,   32'h18,      1,  1, 32'h8,       32'hC000_0008, 0);
      // reset, queue 3 entries, redirect flush to 0x40
      add(1, 0, 32'h0,        0,   32'h1C,      0,  1, 32'hC,       32'hC000_000C, 0);
      add(0, 0, 32'h0,        0,   32'h0,       1,  0, 32'h0,       32'h0,        0);
      add(0, 0, 32'h0,        0,   32'h4,       1,  1, 32'h0,       32'h0050_0093, 0);
      add(0, 0, 32'h0,        0,   32'h8,       1,  1, 32'h0,       32'h0050_0093, 0);
      add(0, 1, 32'h40,       0,   32'hC,       0,  1, 32'h0,       32'h0050_0093, 0);
      add(0, 0, 32'h0,        1,   32'h40,      1,  0, 32'h0,       32'h0,        0);
      add(0, 0, 32'h0,        1,   32'h44,      1,  1, 32'h40,      32'hC000_0040, 0);
      // bounds fault: redirect to 0x3FC, fault at 0x400, HALT holds
      add(0, 1, 32'h3FC,      1,   32'h48,      0,  1, 32'h44,      32'hC000_0044, 0);
      add(0, 0, 32'h0,        1,   32'h3FC,     1,  0, 32'h0,       32'h0,        0);
      add(0, 0, 32'h0,        1,   32'h400,     0,  1, 32'h3FC,     32'hC000_03FC, 0);
      add(0, 0, 32'h0,        1,   32'h400,     0,  1, 32'h400,     32'h0000_0013, 1);
      add(0, 0, 32'h0,        1,   32'h400,     0,  0, 32'h0,       32'h0,        0);
      add(0, 0, 32'h0,        1,   32'h400,     0,  0, 32'h0,       32'h0,        0);
      // misaligned redirect to 0x42, then resume at 0x0
      add(0, 1, 32'h42,       1,   32'h400,     0,  0, 32'h0,       32'h0,        0);
      add(0, 0, 32'h0,        0,   32'h42,      0,  0, 32'h0,       32'h0,        0);
      add(0, 0, 32'h0,        0,   32'h42,      0,  1, 32'h42,      32'h0000_0013, 1);
      add(0, 0, 32'h0,        1,   32'h42,      0,  1, 32'h42,      32'h0000_0013, 1);
      add(0, 0, 32'h0,        1,   32'h42,      0,  0, 32'h0,       32'h0,        0);
      add(0, 1, 32'h0,        1,   32'h42,      0,  0, 32'h0,       32'h0,        0);
      add(0, 0, 32'h0,        1,   32'h0,       1,  0, 32'h0,       32'h0,        0);
      add(0, 0, 32'h0,        1,   32'h4,       1,  1, 32'h0,       32'h0050_0093, 0);
      // fill queue, then reset with a redirect in the same cycle
      add(0, 0, 32'h0,        0,   32'h8,       1,  1, 32'h4,       32'h00a0_0113, 0);
      add(0, 0, 32'h0,        0,   32'hC,       1,  1, 32'h4,       32'h00a0_0113, 0);
      add(0, 0, 32'h0,        0,   32'h10,      1,  1, 32'h4,       32'h00a0_0113, 0);
      add(0, 0, 32'h0,        0,   32'h14,      0,  1, 32'h4,       32'h00a0_0113, 0);
      add(1, 1, 32'h80,       0,   32'h14,      0,  1, 32'h4,       32'h00a0_0113, 0);
      add(0, 0, 32'h0,        0,   32'h0,       1,  0, 32'h0,       32'h0,        0);
      // pc[31] set is a fault regardless of alignment
      add(0, 1, 32'h8000_0000, 0,  32'h4,       0,  1, 32'h0,       32'h0050_0093, 0);
      add(0, 0, 32'h0,        0,   32'h8000_0000, 0, 0, 32'h0,      32'h0,        0);
      add(0, 0, 32'h0,        0,   32'h8000_0000, 0, 1, 32'h8000_0000, 32'h0000_0013, 1);

      foreach (vecs[i]) begin
         rst = vecs[i].rst; redirect_valid = vecs[i].rv;
         redirect_pc = vecs[i].rpc; out_ready = vecs[i].rdy;
         @(negedge clk);
         check($sformatf("vec%0d", i), vecs[i].exp);
         @(posedge clk); #1;
      end

      // Throughput: one fetch and one pop per cycle from reset.
      rst = 1'b1; redirect_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check_bit($sformatf("tput_ren%0d", i), 32'(imem_read_en), 32'h1);
         check_bit($sformatf("tput_addr%0d", i), imem_addr, 32'(4 * i));
         if (i > 0) begin
            check_bit($sformatf("tput_ov%0d", i), 32'(out_valid), 32'h1);
            check_bit($sformatf("tput_pc%0d", i), out_pc, 32'(4 * (i - 1)));
         end
         @(posedge clk); #1;
      end

      // Run up to the top of memory and wait (bounded) for the fault entry.
      redirect_valid = 1'b1; redirect_pc = 32'h3F0;
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      begin
         int cyc;
         cyc = 0;
         while (!(out_valid && out_fault) && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
         end
         if (cyc >= 20) begin
            total++; bad++;
            $display("FAIL fault_wait: no fault entry within 20 cycles");
         end else begin
            check_bit("fault_pc", out_pc, 32'h400);
            check_bit("fault_insn", out_insn, 32'h0000_0013);
            check_bit("fault_ren", 32'(imem_read_en), 32'h0);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of `imemory`. It owns the program counter, drives `imemory`'s address and read enable, and captures the returned word into a small in-order instruction queue. The queue presents `{pc, instruction, fault}` to decode over a valid/ready handshake. It handles backpressure, branch/jump redirects with queue flush, and out-of-range or misaligned fetch faults.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `MEM_DEPTH`, default 1024: byte size of the attached `imemory`, used for the bounds check.
- `QUEUE_DEPTH`, default 4: instruction queue entries; power of two, ≥2.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `imem_addr`  out  32  fetch address to `imemory.addr`; equals the current PC at all times.
- `imem_read_en`  out  1  to `imemory.read_en`; high only in a cycle that issues a fetch.
- `imem_data`  in  32  combinational word returned by `imemory.data_out` in the same cycle.
- `redirect_valid`  in  1  redirect request from execute (taken branch or jump).
- `redirect_pc`  in  32  redirect target.
- `out_valid`  out  1  queue head is valid.
- `out_ready`  in  1  decode accepts the head this cycle.
- `out_pc`  out  32  PC of the head entry.
- `out_insn`  out  32  instruction of the head entry.
- `out_fault`  out  1  head entry is a fetch fault.

## Operation
- State: `pc`, the queue (`rd_ptr`, `wr_ptr`, `count`), and a two-state FSM: RUN and HALT.
- Pop: `pop = out_valid && out_ready`. The head advances and `rd_ptr` wraps modulo QUEUE_DEPTH.
- Space: `space = (count < QUEUE_DEPTH) || pop`. A full queue can accept a push in the same cycle as a pop.
- Fault condition on the current PC: `pc[1:0] != 0`, or `pc[31]`, or `pc >= MEM_DEPTH-3`.
- RUN, no redirect, space, no fault:
  - Assert `imem_read_en`.
  - Push `{pc, imem_data, 0}`.
  - Update `pc <= pc + 4`; the addition is modulo 2^32.
- RUN, no redirect, space, fault:
  - Keep `imem_read_en` low.
  - Push `{pc, 32'h0000_0013, 1}`.
  - Hold `pc` and move to HALT.
- RUN, no space: no fetch, `imem_read_en` low, `pc` holds.
- HALT: no fetch. The FSM stays in HALT until a redirect. The already-queued entries, including the fault entry, drain normally.
- Redirect (any state), with priority over fetch:
  - Flush the queue: `count`, `rd_ptr` and `wr_ptr` go to 0.
  - Load `pc <= redirect_pc` and move to RUN.
  - No fetch or push that cycle, so `imem_read_en` is low.
  - A pop in the same cycle is still a completed handshake; decode owns that entry.
- `out_valid = (count != 0)`. `out_pc`, `out_insn` and `out_fault` come from the head entry and are 0 when the queue is empty.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.

## Timing
- Reset (`rst` high at an edge) gives:
  - `pc = RESET_PC`, `count = 0`, state RUN.
  - `out_valid = 0`; `out_pc`, `out_insn` and `out_fault` = 0.
  - `imem_read_en = 0` in every cycle `rst` is high.
- Reset mid-operation discards all queued entries and overrides a redirect in the same cycle.
- Fetch latency: a fetch issued in cycle N is visible at the queue head in cycle N+1, if the queue was empty. There is no combinational bypass from `imem_data` to `out_insn`.
- Redirect in cycle N:
  - `out_valid = 0` and `imem_addr = redirect_pc` in N+1, with the fetch issued in N+1.
  - The target is at the head in N+2.
- Throughput: one instruction per cycle with `out_ready` held high.
- Outputs depend only on registered state, except `imem_read_en`, which also depends on `redirect_valid`, `rst`, `out_ready` (through `space`) and the fault check.

## Test plan
- Basic stream:
  - Stimulus: memory holds 0x00500093 @0 and 0x00a00113 @4; release reset, `out_ready=1`.
  - Required response: cycle 0 fetches 0 (`imem_read_en=1`). Cycle 1 shows `out_valid=1`, `out_pc=0`, `out_insn=0x00500093`. Cycle 2 shows `out_pc=4`, `out_insn=0x00a00113`.
- Backpressure:
  - Stimulus: `out_ready=0` for 10 cycles, then 1.
  - Required response: exactly 4 fetches (0x0, 0x4, 0x8, 0xC), then `imem_read_en=0` with `pc=0x10`. On release, entries drain in order, and the fetch of 0x10 issues in the first pop cycle.
- Redirect flush:
  - Stimulus: with 3 entries queued, pulse `redirect_valid` with `redirect_pc=0x40`.
  - Required response: next cycle `out_valid=0`, `imem_addr=0x40`, `imem_read_en=1`. The cycle after, `out_pc=0x40`, and no stale entry appears.
- Bounds fault (MEM_DEPTH=1024):
  - Stimulus: redirect to 0x3FC.
  - Required response: 0x3FC is fetched normally. 0x400 produces an entry with `out_fault=1` and `out_insn=0x00000013`. `imem_read_en` stays 0 and the FSM stays in HALT until the next redirect.
- Misaligned:
  - Stimulus: redirect to 0x42.
  - Required response: no read is issued, a single fault entry appears with `out_pc=0x42`, then HALT. A subsequent redirect to 0x0 resumes fetching.
- Reset mid-run:
  - Stimulus: assert `rst` with the queue full and `redirect_valid=1` in the same cycle.
  - Required response: next cycle `out_valid=0` and `imem_addr=RESET_PC`; the redirect is ignored.
